// File: rtl/adc_pkg.sv
// Shared types for the ADC sweep sequencer: widths, sequencer states and the
// sample FIFO entry layout.
package adc_pkg;

  localparam int unsigned ADC_DATA_W = 12;
  localparam int unsigned ADC_CH_W   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRsp
  } seq_state_e;

  typedef struct packed {
    logic [ADC_DATA_W-1:0] data;
    logic [ADC_CH_W-1:0]   channel;
    logic                  last;
  } adc_entry_t;

endpackage

// File: rtl/adc_sample_fifo.sv
// Show-ahead sample FIFO: head is visible whenever valid, pop on valid && pop.
// A push is accepted when full only if a pop frees a slot in the same cycle.
module adc_sample_fifo
  import adc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  adc_entry_t push_data,
  input  logic       pop,
  output adc_entry_t head,
  output logic       valid,
  output logic       full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  adc_entry_t      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign valid   = (count_q != '0);
  assign full    = (count_q == CntFull);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/adc_sequencer.sv
// Periodic ADC channel sweeper: issues one command per channel on each tick,
// collects responses into a sample FIFO and keeps sticky error flags.
module adc_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 1000,
  parameter int unsigned CH_FIRST = 1,
  parameter int unsigned CH_COUNT = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear_err,
  output logic                  cmd_valid,
  output logic [ADC_CH_W-1:0]   cmd_channel,
  output logic                  cmd_sop,
  output logic                  cmd_eop,
  input  logic                  cmd_ready,
  input  logic                  rsp_valid,
  input  logic [ADC_CH_W-1:0]   rsp_channel,
  input  logic [ADC_DATA_W-1:0] rsp_data,
  output logic                  smp_valid,
  input  logic                  smp_ready,
  output logic [ADC_DATA_W-1:0] smp_data,
  output logic [ADC_CH_W-1:0]   smp_channel,
  output logic                  smp_last,
  output logic                  err_timeout,
  output logic                  err_channel,
  output logic                  err_overrun,
  output logic [15:0]           drop_count
);

  localparam int unsigned TickW = $clog2(CLK_DIV);
  localparam int unsigned TmoW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(CLK_DIV - 1);
  localparam logic [TmoW-1:0]  TmoMax  = TmoW'(TIMEOUT);
  localparam logic [2:0]       IdxLast = 3'(CH_COUNT - 1);

  seq_state_e          state_q, state_d;
  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_channel_q, err_channel_d;
  logic                err_overrun_q, err_overrun_d;
  logic [15:0]         drop_q, drop_d;
  logic                tick, advance, push, ev_timeout, ev_channel, drop_ev;
  logic                fifo_full;
  logic [ADC_CH_W-1:0] exp_ch;
  adc_entry_t          push_entry, head;

  assign tick   = (tick_cnt_q == TickMax);
  assign exp_ch = ADC_CH_W'(CH_FIRST) + ADC_CH_W'(idx_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    cmd_valid  = 1'b0;
    advance    = 1'b0;
    push       = 1'b0;
    ev_timeout = 1'b0;
    ev_channel = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick && enable) begin
          state_d = StIssue;
          idx_d   = '0;
        end
      end
      StIssue: begin
        // Held until accepted, even if enable drops meanwhile.
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          state_d = StWaitRsp;
          tmo_d   = '0;
        end
      end
      StWaitRsp: begin
        if (rsp_valid) begin
          advance = 1'b1;
          if (rsp_channel == exp_ch) push = 1'b1;
          else                       ev_channel = 1'b1;
        end else if (tmo_q == TmoMax) begin
          advance    = 1'b1;
          ev_timeout = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (advance) begin
          if ((idx_q < IdxLast) && enable) begin
            state_d = StIssue;
            idx_d   = idx_q + 3'd1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  assign push_entry = '{data: rsp_data, channel: rsp_channel, last: (idx_q == IdxLast)};
  assign drop_ev    = push && fifo_full && !(smp_valid && smp_ready);

  // Error events win over a simultaneous clear.
  always_comb begin
    err_timeout_d = (err_timeout_q && !clear_err) || ev_timeout;
    err_channel_d = (err_channel_q && !clear_err) || ev_channel;
    err_overrun_d = (err_overrun_q && !clear_err) || (tick && (state_q != StIdle));
    drop_d        = clear_err ? 16'd0 : drop_q;
    if (drop_ev && (drop_d != 16'hFFFF)) drop_d = drop_d + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      tick_cnt_q    <= '0;
      idx_q         <= '0;
      tmo_q         <= '0;
      err_timeout_q <= 1'b0;
      err_channel_q <= 1'b0;
      err_overrun_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      err_timeout_q <= err_timeout_d;
      err_channel_q <= err_channel_d;
      err_overrun_q <= err_overrun_d;
      drop_q        <= drop_d;
    end
  end

  adc_sample_fifo #(
    .DEPTH(4)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (smp_ready),
    .head     (head),
    .valid    (smp_valid),
    .full     (fifo_full)
  );

  assign cmd_channel = exp_ch;
  assign cmd_sop     = cmd_valid;
  assign cmd_eop     = cmd_valid;
  assign smp_data    = head.data;
  assign smp_channel = head.channel;
  assign smp_last    = head.last;
  assign err_timeout = err_timeout_q;
  assign err_channel = err_channel_q;
  assign err_overrun = err_overrun_q;
  assign drop_count  = drop_q;

endmodule
